// File: rtl/ssd1306_sink_if.sv
// ssd1306_sink_if
//   Bundles the SSD1306 4-wire SPI stream and the decoded outputs of
//   the panel model.
//   master modport: the OLED driver / bench side. It drives cs, dc, sclk
//                   and mosi, and observes the decoded outputs.
//   slave modport:  ssd1306_sink. It receives the SPI stream and drives
//                   the framebuffer write port and the display state.
//   Signals:
//     cs, dc, sclk, mosi : SPI stream. cs is active low; dc is 1 for data.
//     fb_we, fb_addr, fb_wdata : framebuffer write port, fb_addr = {page, col}.
//     display_on, contrast : panel state set by commands.
//     frame_done, cmd_unknown : one-cycle event pulses.
interface ssd1306_sink_if #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
);
  localparam int AW = $clog2(PAGES) + $clog2(COLS);

  logic          cs;
  logic          dc;
  logic          sclk;
  logic          mosi;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_wdata;
  logic          display_on;
  logic [7:0]    contrast;
  logic          frame_done;
  logic          cmd_unknown;

  modport master (
    output cs, dc, sclk, mosi,
    input  fb_we, fb_addr, fb_wdata, display_on, contrast, frame_done, cmd_unknown
  );

  modport slave (
    input  cs, dc, sclk, mosi,
    output fb_we, fb_addr, fb_wdata, display_on, contrast, frame_done, cmd_unknown
  );
endinterface

// File: rtl/ssd1306_sink.sv
// ssd1306_sink
//   Receive-side model of the SSD1306 OLED SPI interface. It deserialises
//   the 4-wire SPI stream, decodes command bytes into addressing and
//   display state, and turns data bytes into framebuffer writes in
//   horizontal addressing mode.
//   Ports:
//     clk_i : system clock. All logic runs on its rising edge.
//     rst_i : synchronous reset, active low.
//     bus   : ssd1306_sink_if slave modport. It carries the SPI inputs
//             (cs, dc, sclk, mosi) and the framebuffer/state outputs.
module ssd1306_sink #(
  parameter int COLS  = 128,
  parameter int PAGES = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ssd1306_sink_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  localparam logic [7:0] OP_DISP_OFF = 8'hAE;
  localparam logic [7:0] OP_DISP_ON  = 8'hAF;
  localparam logic [7:0] OP_CONTRAST = 8'h81;
  localparam logic [7:0] OP_MODE     = 8'h20;
  localparam logic [7:0] OP_CLKDIV   = 8'hD5;
  localparam logic [7:0] OP_COLADDR  = 8'h21;
  localparam logic [7:0] OP_PAGEADDR = 8'h22;
  localparam logic [7:0] OP_NOP      = 8'hE3;

  typedef enum logic [1:0] {ST_OP, ST_ARG1, ST_ARG2} dec_state_e;

  logic [1:0] cs_sync_q;
  logic [1:0] dc_sync_q;
  logic [1:0] mosi_sync_q;
  logic [2:0] sclk_sync_q;
  logic       sclk_rise;

  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       byte_valid_q;
  logic       byte_dc_q;

  dec_state_e    state_q;
  logic [7:0]    opcode_q;
  logic [CW-1:0] col_start_q, col_end_q, col_q;
  logic [PW-1:0] page_start_q, page_end_q, page_q;
  logic          display_on_q;
  logic [7:0]    contrast_q;
  logic          fb_we_q;
  logic [PW+CW-1:0] fb_addr_q;
  logic [7:0]    fb_wdata_q;
  logic          frame_done_q;
  logic          cmd_unknown_q;

  logic [CW-1:0] col_inc, col_d;
  logic [PW-1:0] page_inc, page_d;
  logic          wrap_d;

  // The SPI inputs are asynchronous to clk. Each one goes through two flops.
  // sclk gets a third flop, so an edge is seen as "new high, old low".
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sclk_sync_q <= 3'b000;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], bus.cs};
      dc_sync_q   <= {dc_sync_q[0], bus.dc};
      mosi_sync_q <= {mosi_sync_q[0], bus.mosi};
      sclk_sync_q <= {sclk_sync_q[1:0], bus.sclk};
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];

  // The bit counter wraps from 7 to 0 on the 8th bit, which starts the next
  // byte cleanly. shift_q holds the finished byte until the next sclk edge.
  // That edge comes at least 4 clk later, so the decoder can read shift_q
  // one cycle after byte_valid_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_valid_q <= 1'b0;
      byte_dc_q    <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (cs_sync_q[1]) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise) begin
        shift_q   <= {shift_q[6:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          byte_dc_q    <= dc_sync_q[1];
        end
      end
    end
  end

  // Horizontal-mode pointer advance. A window with start > end wraps
  // through the top of the column/page range.
  always_comb begin
    col_inc  = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
    page_inc = (page_q == PW'(PAGES - 1)) ? '0 : page_q + PW'(1);
    col_d    = col_q;
    page_d   = page_q;
    wrap_d   = 1'b0;
    if (col_q != col_end_q) begin
      col_d = col_inc;
    end else begin
      col_d = col_start_q;
      if (page_q != page_end_q) begin
        page_d = page_inc;
      end else begin
        page_d = page_start_q;
        wrap_d = 1'b1;
      end
    end
  end

  // Byte decoder. Data bytes always write, even in the middle of a command
  // sequence, and leave the decoder state alone. Command bytes go through
  // OP -> ARG1 -> ARG2 according to the opcode latched in opcode_q.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_OP;
      opcode_q      <= 8'h00;
      col_start_q   <= '0;
      col_end_q     <= CW'(COLS - 1);
      page_start_q  <= '0;
      page_end_q    <= PW'(PAGES - 1);
      col_q         <= '0;
      page_q        <= '0;
      display_on_q  <= 1'b0;
      contrast_q    <= 8'h7F;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= 8'h00;
      frame_done_q  <= 1'b0;
      cmd_unknown_q <= 1'b0;
    end else begin
      fb_we_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      cmd_unknown_q <= 1'b0;
      if (byte_valid_q) begin
        if (byte_dc_q) begin
          fb_we_q      <= 1'b1;
          fb_addr_q    <= {page_q, col_q};
          fb_wdata_q   <= shift_q;
          col_q        <= col_d;
          page_q       <= page_d;
          frame_done_q <= wrap_d;
        end else begin
          unique case (state_q)
            ST_OP: begin
              case (shift_q)
                OP_DISP_OFF: display_on_q <= 1'b0;
                OP_DISP_ON:  display_on_q <= 1'b1;
                OP_CONTRAST, OP_MODE, OP_CLKDIV, OP_COLADDR, OP_PAGEADDR: begin
                  opcode_q <= shift_q;
                  state_q  <= ST_ARG1;
                end
                OP_NOP: begin
                end
                default: cmd_unknown_q <= 1'b1;
              endcase
            end
            ST_ARG1: begin
              state_q <= ST_OP;
              case (opcode_q)
                OP_CONTRAST: contrast_q <= shift_q;
                // Only horizontal addressing (0x00) is modelled.
                OP_MODE: begin
                  if (shift_q != 8'h00) cmd_unknown_q <= 1'b1;
                end
                OP_COLADDR: begin
                  col_start_q <= shift_q[CW-1:0];
                  state_q     <= ST_ARG2;
                end
                OP_PAGEADDR: begin
                  page_start_q <= shift_q[PW-1:0];
                  state_q      <= ST_ARG2;
                end
                default: begin
                end
              endcase
            end
            ST_ARG2: begin
              state_q <= ST_OP;
              case (opcode_q)
                OP_COLADDR: begin
                  col_end_q <= shift_q[CW-1:0];
                  col_q     <= col_start_q;
                end
                OP_PAGEADDR: begin
                  page_end_q <= shift_q[PW-1:0];
                  page_q     <= page_start_q;
                end
                default: begin
                end
              endcase
            end
            default: state_q <= ST_OP;
          endcase
        end
      end
    end
  end

  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_wdata    = fb_wdata_q;
  assign bus.display_on  = display_on_q;
  assign bus.contrast    = contrast_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.cmd_unknown = cmd_unknown_q;
endmodule

// File: tb/tb_ssd1306_sink.sv
// tb_ssd1306_sink
//   Drives SPI command and data byte sequences into ssd1306_sink.
//   Expected framebuffer writes are queued when each data byte is sent.
//   A negedge monitor pops and compares them as fb_we strobes appear.
module tb_ssd1306_sink;
  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  ssd1306_sink_if #(.COLS(128), .PAGES(8)) bus ();

  ssd1306_sink #(.COLS(128), .PAGES(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic       fd;
  } wr_t;

  wr_t  expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   unkCount    = 0;
  int   weCount     = 0;
  int   pushCount   = 0;
  logic prevUnk     = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: each write strobe must match the oldest queued write.
  // cmd_unknown is counted, and every pulse must be exactly one cycle wide.
  always @(negedge clk_i) begin
    wr_t e;
    if (bus.cmd_unknown === 1'b1) begin
      unkCount++;
      checkOutput("cmd_unknown_pulse_width", {31'b0, prevUnk}, 32'd0);
    end
    prevUnk = (bus.cmd_unknown === 1'b1);
    if (bus.fb_we === 1'b1) begin
      weCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write_queue_depth", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("fb_addr", {22'b0, bus.fb_addr}, {22'b0, e.addr});
        checkOutput("fb_wdata", {24'b0, bus.fb_wdata}, {24'b0, e.data});
        checkOutput("frame_done", {31'b0, bus.frame_done}, {31'b0, e.fd});
      end
    end else if (bus.frame_done === 1'b1) begin
      checkOutput("frame_done_without_we", {31'b0, bus.fb_we}, 32'd1);
    end
  end

  task automatic sendBits(input logic dcVal, input logic [7:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      bus.sclk = 1'b0;
      bus.dc   = dcVal;
      bus.mosi = val[7-i];
      repeat (2) @(negedge clk_i);
      bus.sclk = 1'b1;
      repeat (2) @(negedge clk_i);
    end
  endtask

  task automatic applyStimulus(input logic dcVal, input logic [7:0] val);
    sendBits(dcVal, val, 8);
    @(negedge clk_i);
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic sendData(input logic [7:0] val, input logic [9:0] addr, input logic fd);
    wr_t e;
    e.addr = addr;
    e.data = val;
    e.fd   = fd;
    expQ.push_back(e);
    pushCount++;
    applyStimulus(1'b1, val);
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk_i);
    checkOutput(tag, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_i    = 1'b0;
    bus.cs   = 1'b1;
    bus.dc   = 1'b0;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_fb_we", {31'b0, bus.fb_we}, 32'd0);
    checkOutput("rst_display_on", {31'b0, bus.display_on}, 32'd0);
    checkOutput("rst_contrast", {24'b0, bus.contrast}, 32'h7F);
    checkOutput("rst_fb_addr", {22'b0, bus.fb_addr}, 32'd0);
    checkOutput("rst_fb_wdata", {24'b0, bus.fb_wdata}, 32'd0);
    checkOutput("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
    checkOutput("rst_cmd_unknown", {31'b0, bus.cmd_unknown}, 32'd0);
    rst_i = 1'b1;
    bus.cs = 1'b0;
    repeat (4) @(negedge clk_i);

    // Display on: check the exact E3 timing of the 8th bit.
    sendBits(1'b0, 8'hAF, 7);
    @(negedge clk_i);
    bus.sclk = 1'b0;
    bus.mosi = 1'b1;
    repeat (2) @(negedge clk_i);
    bus.sclk = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("display_on_before_E3", {31'b0, bus.display_on}, 32'd0);
    @(negedge clk_i);
    checkOutput("display_on_after_E3", {31'b0, bus.display_on}, 32'd1);
    bus.sclk = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("unk_after_AF", 32'(unkCount), 32'd0);

    // Full-screen window, 1024 bytes, then wrap to address 0.
    applyStimulus(1'b0, 8'h21); applyStimulus(1'b0, 8'h00); applyStimulus(1'b0, 8'h7F);
    applyStimulus(1'b0, 8'h22); applyStimulus(1'b0, 8'h00); applyStimulus(1'b0, 8'h07);
    for (int i = 0; i < 1024; i++) sendData(8'(i), 10'(i), (i == 1023));
    sendData(8'h3C, 10'h000, 1'b0);
    waitDrain("drain_full_frame");

    // Small window: columns 0x10-0x11, pages 6-7.
    applyStimulus(1'b0, 8'h21); applyStimulus(1'b0, 8'h10); applyStimulus(1'b0, 8'h11);
    applyStimulus(1'b0, 8'h22); applyStimulus(1'b0, 8'h06); applyStimulus(1'b0, 8'h07);
    sendData(8'h01, 10'h310, 1'b0);
    sendData(8'h02, 10'h311, 1'b0);
    sendData(8'h03, 10'h390, 1'b0);
    sendData(8'h04, 10'h391, 1'b1);
    sendData(8'h05, 10'h310, 1'b0);
    waitDrain("drain_window");

    // Contrast, unknown opcode, NOP, unsupported mode, display off.
    applyStimulus(1'b0, 8'h81); applyStimulus(1'b0, 8'h40);
    checkOutput("contrast", {24'b0, bus.contrast}, 32'h40);
    applyStimulus(1'b0, 8'hB5);
    checkOutput("unk_after_B5", 32'(unkCount), 32'd1);
    applyStimulus(1'b0, 8'hE3);
    checkOutput("unk_after_NOP", 32'(unkCount), 32'd1);
    applyStimulus(1'b0, 8'h20); applyStimulus(1'b0, 8'h01);
    checkOutput("unk_after_mode", 32'(unkCount), 32'd2);
    sendData(8'h11, 10'h311, 1'b0);
    sendData(8'h12, 10'h390, 1'b0);
    applyStimulus(1'b0, 8'hAE);
    checkOutput("display_off", {31'b0, bus.display_on}, 32'd0);

    // A partial byte aborted by cs is dropped. The next whole byte writes once.
    sendBits(1'b1, 8'hFF, 5);
    @(negedge clk_i);
    bus.sclk = 1'b0;
    bus.cs   = 1'b1;
    repeat (10) @(negedge clk_i);
    bus.cs = 1'b0;
    repeat (3) @(negedge clk_i);
    sendData(8'hA5, 10'h391, 1'b1);
    waitDrain("drain_partial");
    checkOutput("write_count", 32'(weCount), 32'(pushCount));

    // Reset in the middle of a 0x22 sequence.
    applyStimulus(1'b0, 8'hAF);
    applyStimulus(1'b0, 8'h22); applyStimulus(1'b0, 8'h03);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    checkOutput("mid_rst_display_on", {31'b0, bus.display_on}, 32'd0);
    checkOutput("mid_rst_contrast", {24'b0, bus.contrast}, 32'h7F);
    repeat (4) @(negedge clk_i);
    applyStimulus(1'b0, 8'hAF);
    checkOutput("decoder_in_op_after_rst", {31'b0, bus.display_on}, 32'd1);
    sendData(8'h5A, 10'h000, 1'b0);
    applyStimulus(1'b0, 8'h21); applyStimulus(1'b0, 8'h00); applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < 8; k++) sendData(8'(8'hC0 + k), 10'(k * 128), (k == 7));
    waitDrain("drain_after_rst");
    checkOutput("unk_final", 32'(unkCount), 32'd2);
    checkOutput("write_count_final", 32'(weCount), 32'(pushCount));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
